// File: rtl/sonar_adc_capture_ctrl.sv
// Sonar ADC capture controller: sequences cs_n/sclk for one serial ADC
// channel and presents each captured 14-bit sample on a valid/ready port.
// Ports: clk, reset (async, active-high), enable, trigger, clear_flags,
//   adc_sdata in; adc_cs_n, adc_sclk out; busy; sample/sample_valid with
//   sample_ready; sticky overrun and trig_miss flags.
module sonar_adc_capture_ctrl #(
    parameter int CLK_DIV      = 4,
    parameter int LEAD_BITS    = 2,
    parameter int DATA_BITS    = 14,
    parameter int QUIET_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        trigger,
    input  logic        clear_flags,
    input  logic        adc_sdata,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        busy,
    output logic [13:0] sample,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        overrun,
    output logic        trig_miss
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] QUIET = 3'd4;

    localparam int N = LEAD_BITS + DATA_BITS;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [7:0]  BIT_LAST = 8'(N - 1);
    // DONE already accounts for one quiet cycle, so QUIET holds the rest.
    localparam logic [15:0] Q_LAST =
        16'((QUIET_CYCLES > 1) ? (QUIET_CYCLES - 2) : 0);
    localparam logic [2:0] AFTER_DONE =
        (QUIET_CYCLES > 1) ? QUIET : IDLE;

    logic [2:0]  state;
    logic [15:0] div_cnt;
    logic [7:0]  bit_cnt;
    logic [15:0] q_cnt;
    logic        phase;
    logic [13:0] sreg;
    logic        div_end;
    logic        ovr_set;
    logic        miss_set;

    assign div_end  = (div_cnt == DIV_LAST);
    assign busy     = (state != IDLE);
    assign adc_cs_n = !((state == SETUP) || (state == SHIFT));
    assign adc_sclk = !((state == SHIFT) && !phase);

    assign ovr_set  = (state == DONE) && sample_valid && !sample_ready;
    assign miss_set = trigger && enable && (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            q_cnt   <= '0;
            phase   <= 1'b0;
            sreg    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trigger && enable) begin
                        state   <= SETUP;
                        div_cnt <= '0;
                    end
                end
                SETUP: begin
                    if (div_end) begin
                        state   <= SHIFT;
                        div_cnt <= '0;
                        phase   <= 1'b0;
                        bit_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                SHIFT: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        if (!phase) begin
                            // Capture on the edge ending the low phase.
                            sreg  <= {sreg[12:0], adc_sdata};
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                state <= DONE;
                            end else begin
                                bit_cnt <= bit_cnt + 8'd1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                DONE: begin
                    q_cnt <= '0;
                    state <= AFTER_DONE;
                end
                QUIET: begin
                    if (q_cnt == Q_LAST) begin
                        state <= IDLE;
                    end else begin
                        q_cnt <= q_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            trig_miss    <= 1'b0;
        end else begin
            if (state == DONE) begin
                sample       <= sreg;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            // Set events take priority over a simultaneous clear.
            overrun   <= ovr_set  | (overrun   & ~clear_flags);
            trig_miss <= miss_set | (trig_miss & ~clear_flags);
        end
    end

endmodule

// File: tb/tb_sonar_adc_capture_ctrl.sv
// Directed bench for sonar_adc_capture_ctrl: default instance plus a
// CLK_DIV=1/LEAD_BITS=0 instance, each with a behavioural serial ADC.
module tb_sonar_adc_capture_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b1;
    logic clear_flags = 1'b0;

    logic trig_a = 1'b0, ready_a = 1'b1, sd_a;
    logic cs_a, sclk_a, busy_a, valid_a, ovr_a, miss_a;
    logic [13:0] smp_a;

    logic trig_b = 1'b0, ready_b = 1'b0, sd_b;
    logic cs_b, sclk_b, busy_b, valid_b, ovr_b, miss_b;
    logic [13:0] smp_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sonar_adc_capture_ctrl dut_a (
        .clk(clk), .reset(reset), .enable(enable), .trigger(trig_a),
        .clear_flags(clear_flags), .adc_sdata(sd_a), .adc_cs_n(cs_a),
        .adc_sclk(sclk_a), .busy(busy_a), .sample(smp_a),
        .sample_valid(valid_a), .sample_ready(ready_a),
        .overrun(ovr_a), .trig_miss(miss_a)
    );

    sonar_adc_capture_ctrl #(
        .CLK_DIV(1), .LEAD_BITS(0), .DATA_BITS(14), .QUIET_CYCLES(8)
    ) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .trigger(trig_b),
        .clear_flags(clear_flags), .adc_sdata(sd_b), .adc_cs_n(cs_b),
        .adc_sclk(sclk_b), .busy(busy_b), .sample(smp_b),
        .sample_valid(valid_b), .sample_ready(ready_b),
        .overrun(ovr_b), .trig_miss(miss_b)
    );

    // ADC models: bit index resets on cs_n fall, advances on sclk rise.
    logic [15:0] fa = '0;
    int ia = 0;
    assign sd_a = (ia < 16) ? fa[15 - ia] : 1'b0;
    always @(negedge cs_a) ia = 0;
    always @(posedge sclk_a) if (!cs_a) ia = ia + 1;

    logic [13:0] fb = '0;
    int ib = 0;
    assign sd_b = (ib < 14) ? fb[13 - ib] : 1'b0;
    always @(negedge cs_b) ib = 0;
    always @(posedge sclk_b) if (!cs_b) ib = ib + 1;

    typedef struct {
        int   cyc;
        logic cs_n;
        logic sclk;
        logic busy;
        logic valid;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Leaves the bench at the sampling point of cycle 1.
    task automatic start_a();
        trig_a = 1'b1;
        @(negedge clk);
        trig_a = 1'b0;
    endtask

    task automatic start_b();
        trig_b = 1'b1;
        @(negedge clk);
        trig_b = 1'b0;
    endtask

    task automatic wait_idle(input bit use_b);
        int n = 0;
        while ((use_b ? busy_b : busy_a) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", 32'(n >= 400), 32'd0);
    endtask

    initial begin
        int lows;
        int run;
        int pulses;
        int badw;
        logic prev;

        tbl[0]  = '{1,   0, 1, 1, 0};
        tbl[1]  = '{4,   0, 1, 1, 0};
        tbl[2]  = '{5,   0, 0, 1, 0};
        tbl[3]  = '{8,   0, 0, 1, 0};
        tbl[4]  = '{9,   0, 1, 1, 0};
        tbl[5]  = '{13,  0, 0, 1, 0};
        tbl[6]  = '{128, 0, 0, 1, 0};
        tbl[7]  = '{132, 0, 1, 1, 0};
        tbl[8]  = '{133, 1, 1, 1, 0};
        tbl[9]  = '{134, 1, 1, 1, 1};
        tbl[10] = '{135, 1, 1, 1, 0};
        tbl[11] = '{140, 1, 1, 1, 0};
        tbl[12] = '{141, 1, 1, 0, 0};

        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_cs_n", 32'(cs_a), 32'd1);
        chk("rst_sclk", 32'(sclk_a), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_sample", 32'(smp_a), 32'd0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_flags", {30'd0, ovr_a, miss_a}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Frame 1: 00 then 2A5C, table-driven timing checks.
        fa = {2'b00, 14'h2A5C};
        ready_a = 1'b1;
        start_a();
        lows = 0; run = 0; pulses = 0; badw = 0; prev = 1'b1;
        for (int c = 1; c <= 141; c++) begin
            if (c > 1) @(negedge clk);
            if (!cs_a) lows++;
            if (!sclk_a) run++;
            if (sclk_a && !prev) begin
                pulses++;
                if (run != 4) badw++;
                run = 0;
            end
            prev = sclk_a;
            for (int k = 0; k < 13; k++) begin
                if (tbl[k].cyc == c) begin
                    chk($sformatf("f1_c%0d", c),
                        {28'd0, cs_a, sclk_a, busy_a, valid_a},
                        {28'd0, tbl[k].cs_n, tbl[k].sclk,
                         tbl[k].busy, tbl[k].valid});
                end
            end
            if (c == 134) chk("f1_sample", 32'(smp_a), 32'h2A5C);
        end
        chk("f1_cs_low_cycles", 32'(lows), 32'd132);
        chk("f1_sclk_pulses", 32'(pulses), 32'd16);
        chk("f1_sclk_width", 32'(badw), 32'd0);

        // Overrun: two frames with ready held low.
        ready_a = 1'b0;
        fa = {2'b00, 14'h3FFF};
        start_a();
        wait_idle(1'b0);
        chk("ovr_f1_sample", 32'(smp_a), 32'h3FFF);
        chk("ovr_f1_flag", 32'(ovr_a), 32'd0);
        fa = {2'b00, 14'h0001};
        start_a();
        wait_idle(1'b0);
        chk("ovr_f2_sample", 32'(smp_a), 32'h0001);
        chk("ovr_f2_valid", 32'(valid_a), 32'd1);
        chk("ovr_f2_flag", 32'(ovr_a), 32'd1);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        chk("ovr_cleared", 32'(ovr_a), 32'd0);
        chk("ovr_hold_sample", 32'(smp_a), 32'h0001);
        chk("ovr_hold_valid", 32'(valid_a), 32'd1);
        ready_a = 1'b1;
        @(negedge clk);
        chk("drain_valid", 32'(valid_a), 32'd0);

        // Trigger mid-frame, then trigger on the first IDLE cycle.
        fa = {2'b00, 14'h1A3C};
        start_a();
        repeat (49) @(negedge clk);
        trig_a = 1'b1;
        @(negedge clk);
        trig_a = 1'b0;
        chk("miss_set", 32'(miss_a), 32'd1);
        chk("miss_busy", 32'(busy_a), 32'd1);
        repeat (89) @(negedge clk);
        chk("miss_c140_busy", 32'(busy_a), 32'd1);
        @(negedge clk);
        chk("miss_no_extra", 32'(busy_a), 32'd0);
        chk("miss_sample", 32'(smp_a), 32'h1A3C);
        fa = {2'b00, 14'h0F0F};
        start_a();
        chk("idle1_accept_busy", 32'(busy_a), 32'd1);
        chk("idle1_accept_cs", 32'(cs_a), 32'd0);
        wait_idle(1'b0);
        chk("idle1_sample", 32'(smp_a), 32'h0F0F);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        chk("miss_cleared", 32'(miss_a), 32'd0);

        // Trigger while disabled is ignored.
        enable = 1'b0;
        start_a();
        chk("dis_busy", 32'(busy_a), 32'd0);
        repeat (3) @(negedge clk);
        chk("dis_busy_later", 32'(busy_a), 32'd0);
        chk("dis_miss", 32'(miss_a), 32'd0);
        enable = 1'b1;

        // Asynchronous reset mid-SHIFT.
        fa = {2'b00, 14'h2222};
        start_a();
        repeat (69) @(negedge clk);
        chk("pre_rst_busy", 32'(busy_a), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_cs", 32'(cs_a), 32'd1);
        chk("mid_rst_sclk", 32'(sclk_a), 32'd1);
        chk("mid_rst_busy", 32'(busy_a), 32'd0);
        chk("mid_rst_sample", 32'(smp_a), 32'd0);
        chk("mid_rst_valid", 32'(valid_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        fa = {2'b00, 14'h3C5A};
        start_a();
        wait_idle(1'b0);
        chk("post_rst_sample", 32'(smp_a), 32'h3C5A);

        // CLK_DIV=1, LEAD_BITS=0 instance.
        ready_b = 1'b0;
        fb = 14'h1234;
        start_b();
        repeat (29) @(negedge clk);
        chk("b_c30_valid", 32'(valid_b), 32'd0);
        chk("b_c30_cs", 32'(cs_b), 32'd1);
        @(negedge clk);
        chk("b_c31_valid", 32'(valid_b), 32'd1);
        chk("b_c31_sample", 32'(smp_b), 32'h1234);
        wait_idle(1'b1);
        fb = 14'h2BCD;
        start_b();
        repeat (29) @(negedge clk);
        chk("b_hold_valid", 32'(valid_b), 32'd1);
        chk("b_hold_sample", 32'(smp_b), 32'h1234);
        ready_b = 1'b1;
        @(negedge clk);
        ready_b = 1'b0;
        chk("b_xfer_valid", 32'(valid_b), 32'd1);
        chk("b_xfer_sample", 32'(smp_b), 32'h2BCD);
        chk("b_xfer_ovr", 32'(ovr_b), 32'd0);
        wait_idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
